mlp_weight_sequencer: RTL and testbench

- Streams weight and bias tiles from on-chip parameter memories into one fixed_2d_linear instance, in the order that instance consumes them.
- fixed_mlp instantiates one sequencer per linear layer (in2hidden, hidden2out) and replaces its external weight/bias inputs.
- Memories are synchronous-read, 1-cycle latency. The sequencer hides this latency under valid/ready backpressure without losing or duplicating tiles.

---
 rtl/mlp_ctrl_pkg.sv | 23 ++
 rtl/mlp_param_fifo2.sv | 73 +++++++
 rtl/mlp_weight_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mlp_weight_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_ctrl_pkg.sv
// Shared control definitions for the MLP parameter sequencers.
//   seq_state_t : sequencer FSM state encoding
//   clog2_min1  : ceiling log2 clamped to at least 1, so an address or
//                 counter width never collapses to zero bits
package mlp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    function automatic int clog2_min1(input int value);
        int result;
        if (value <= 1) begin
            result = 1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/mlp_param_fifo2.sv
// Two-entry FIFO that sits behind a synchronous-read parameter memory.
//   clk, rst    : clock, asynchronous active-low reset
//   push, din   : write strobe and data
//   pop         : read strobe; the head advances at the end of the cycle
//   dout        : head entry, held stable until it is popped
//   count       : occupancy, 0..2
// A push into a full FIFO is only accepted together with a pop. A pop of
// an empty FIFO is ignored.
module mlp_param_fifo2
    import mlp_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem0_r;
    logic [DATA_WIDTH-1:0] mem1_r;
    logic [1:0]            count_r;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    end

    // Storage update: mem0_r is always the head entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem0_r  <= {DATA_WIDTH{1'b0}};
            mem1_r  <= {DATA_WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        mem0_r <= din;
                    end else begin
                        mem1_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    mem0_r  <= mem1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new entry lands behind the survivor.
                    if (count_r == 2'd1) begin
                        mem0_r <= din;
                    end else begin
                        mem0_r <= mem1_r;
                        mem1_r <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout  = mem0_r;
    assign count = count_r;

endmodule

// File: rtl/mlp_weight_sequencer.sv
// Streams weight and bias tiles from 1-cycle-latency parameter memories to
// one fixed_2d_linear instance, in its consumption order.
//   start/busy/done         : pass control and status
//   weight_rd_* / bias_rd_* : memory read ports (data valid the cycle after rd_en)
//   weight/bias + valid/ready : tile streams to the linear layer
// Each stream has its own counters, in-flight flag and 2-entry FIFO; the
// streams never wait on each other.
module mlp_weight_sequencer
    import mlp_ctrl_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 16,
    parameter int BIAS_WIDTH   = 16,
    parameter int IN_Y         = 16,
    parameter int IN_X         = 4,
    parameter int W_Y          = 8,
    parameter int UNROLL_IN_Y  = 4,
    parameter int UNROLL_IN_X  = 2,
    parameter int UNROLL_W_Y   = 4,
    localparam int DY   = IN_Y / UNROLL_IN_Y,
    localparam int DX   = IN_X / UNROLL_IN_X,
    localparam int DW   = W_Y / UNROLL_W_Y,
    localparam int WT   = UNROLL_W_Y * UNROLL_IN_X,
    localparam int BT   = UNROLL_W_Y,
    localparam int W_AW = clog2_min1(DW * DX),
    localparam int B_AW = clog2_min1(DW)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       weight_rd_en,
    output logic [W_AW-1:0]            weight_rd_addr,
    input  logic [WT*WEIGHT_WIDTH-1:0] weight_rd_data,
    output logic                       bias_rd_en,
    output logic [B_AW-1:0]            bias_rd_addr,
    input  logic [BT*BIAS_WIDTH-1:0]   bias_rd_data,
    output logic [WEIGHT_WIDTH-1:0]    weight [WT],
    output logic                       weight_valid,
    input  logic                       weight_ready,
    output logic [BIAS_WIDTH-1:0]      bias [BT],
    output logic                       bias_valid,
    input  logic                       bias_ready
);

    localparam int YW = clog2_min1(DY);
    localparam int XW = clog2_min1(DX);
    localparam int WW = clog2_min1(DW);
    localparam logic [YW-1:0] Y_LAST = YW'(DY - 1);
    localparam logic [XW-1:0] X_LAST = XW'(DX - 1);
    localparam logic [WW-1:0] W_LAST = WW'(DW - 1);

    seq_state_t state_r;

    // Weight stream state
    logic [YW-1:0]   wy_r;
    logic [WW-1:0]   ww_r;
    logic [XW-1:0]   wx_r;
    logic            w_left_r;
    logic            w_inflight_r;
    logic [W_AW-1:0] w_addr_r;
    logic [1:0]      w_cnt_s;
    logic [1:0]      w_occ_s;
    logic            w_pop_s;
    logic            w_rd_en_s;
    logic            w_last_s;
    logic            w_done_s;
    logic [W_AW-1:0] w_cur_addr_s;
    logic [WT*WEIGHT_WIDTH-1:0] w_head_s;

    // Bias stream state
    logic [YW-1:0]   by_r;
    logic [WW-1:0]   bw_r;
    logic            b_left_r;
    logic            b_inflight_r;
    logic [B_AW-1:0] b_addr_r;
    logic [1:0]      b_cnt_s;
    logic [1:0]      b_occ_s;
    logic            b_pop_s;
    logic            b_rd_en_s;
    logic            b_last_s;
    logic            b_done_s;
    logic [BT*BIAS_WIDTH-1:0] b_head_s;

    logic            start_pass_s;
    logic            drained_s;

    // Read issue decisions; a same-cycle pop frees a slot for the next read.
    always_comb begin
        start_pass_s = (state_r == IDLE) && start;
        w_pop_s      = (w_cnt_s != 2'd0) && weight_ready;
        b_pop_s      = (b_cnt_s != 2'd0) && bias_ready;
        w_occ_s      = w_cnt_s + {1'b0, w_inflight_r} - {1'b0, w_pop_s};
        b_occ_s      = b_cnt_s + {1'b0, b_inflight_r} - {1'b0, b_pop_s};
        w_rd_en_s    = (state_r == RUN) && w_left_r && (w_occ_s < 2'd2);
        b_rd_en_s    = (state_r == RUN) && b_left_r && (b_occ_s < 2'd2);
        w_last_s     = (wy_r == Y_LAST) && (ww_r == W_LAST) && (wx_r == X_LAST);
        b_last_s     = (by_r == Y_LAST) && (bw_r == W_LAST);
        w_done_s     = !w_left_r || (w_rd_en_s && w_last_s);
        b_done_s     = !b_left_r || (b_rd_en_s && b_last_s);
        w_cur_addr_s = W_AW'(ww_r) * W_AW'(DX) + W_AW'(wx_r);
        drained_s    = (w_cnt_s == 2'd0) && (b_cnt_s == 2'd0) &&
                       !w_inflight_r && !b_inflight_r;
    end

    // Pass control FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (w_done_s && b_done_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (drained_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Weight tile counters: y outermost, then w, then x innermost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wy_r         <= {YW{1'b0}};
            ww_r         <= {WW{1'b0}};
            wx_r         <= {XW{1'b0}};
            w_left_r     <= 1'b0;
            w_inflight_r <= 1'b0;
            w_addr_r     <= {W_AW{1'b0}};
        end else if (start_pass_s) begin
            wy_r         <= {YW{1'b0}};
            ww_r         <= {WW{1'b0}};
            wx_r         <= {XW{1'b0}};
            w_left_r     <= 1'b1;
            w_inflight_r <= 1'b0;
        end else begin
            w_inflight_r <= w_rd_en_s;
            if (w_rd_en_s) begin
                w_addr_r <= w_cur_addr_s;
                if (w_last_s) begin
                    w_left_r <= 1'b0;
                end else begin
                    w_left_r <= 1'b1;
                end
                if (wx_r == X_LAST) begin
                    wx_r <= {XW{1'b0}};
                    if (ww_r == W_LAST) begin
                        ww_r <= {WW{1'b0}};
                        if (wy_r != Y_LAST) begin
                            wy_r <= wy_r + {{(YW-1){1'b0}}, 1'b1};
                        end else begin
                            wy_r <= wy_r;
                        end
                    end else begin
                        ww_r <= ww_r + {{(WW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wx_r <= wx_r + {{(XW-1){1'b0}}, 1'b1};
                end
            end else begin
                w_addr_r <= w_addr_r;
            end
        end
    end

    // Bias tile counters: y outermost, then w.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            by_r         <= {YW{1'b0}};
            bw_r         <= {WW{1'b0}};
            b_left_r     <= 1'b0;
            b_inflight_r <= 1'b0;
            b_addr_r     <= {B_AW{1'b0}};
        end else if (start_pass_s) begin
            by_r         <= {YW{1'b0}};
            bw_r         <= {WW{1'b0}};
            b_left_r     <= 1'b1;
            b_inflight_r <= 1'b0;
        end else begin
            b_inflight_r <= b_rd_en_s;
            if (b_rd_en_s) begin
                b_addr_r <= B_AW'(bw_r);
                if (b_last_s) begin
                    b_left_r <= 1'b0;
                end else begin
                    b_left_r <= 1'b1;
                end
                if (bw_r == W_LAST) begin
                    bw_r <= {WW{1'b0}};
                    if (by_r != Y_LAST) begin
                        by_r <= by_r + {{(YW-1){1'b0}}, 1'b1};
                    end else begin
                        by_r <= by_r;
                    end
                end else begin
                    bw_r <= bw_r + {{(WW-1){1'b0}}, 1'b1};
                end
            end else begin
                b_addr_r <= b_addr_r;
            end
        end
    end

    mlp_param_fifo2 #(.DATA_WIDTH(WT*WEIGHT_WIDTH)) u_weight_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_inflight_r),
        .pop   (w_pop_s),
        .din   (weight_rd_data),
        .dout  (w_head_s),
        .count (w_cnt_s)
    );

    mlp_param_fifo2 #(.DATA_WIDTH(BT*BIAS_WIDTH)) u_bias_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (b_inflight_r),
        .pop   (b_pop_s),
        .din   (bias_rd_data),
        .dout  (b_head_s),
        .count (b_cnt_s)
    );

    // Unpack FIFO heads into per-element tile outputs.
    always_comb begin
        for (int i = 0; i < WT; i++) begin
            weight[i] = w_head_s[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        for (int i = 0; i < BT; i++) begin
            bias[i] = b_head_s[i*BIAS_WIDTH +: BIAS_WIDTH];
        end
    end

    // The address shows the live counter while reading, otherwise the last issued one.
    assign weight_rd_en   = w_rd_en_s;
    assign weight_rd_addr = w_rd_en_s ? w_cur_addr_s : w_addr_r;
    assign bias_rd_en     = b_rd_en_s;
    assign bias_rd_addr   = b_rd_en_s ? B_AW'(bw_r) : b_addr_r;
    assign weight_valid   = (w_cnt_s != 2'd0);
    assign bias_valid     = (b_cnt_s != 2'd0);
    assign busy           = (state_r != IDLE);
    assign done           = (state_r == DRAIN) && drained_s;

endmodule

// File: tb/tb_mlp_weight_sequencer.sv
// Scoreboard bench: each pass pushes its expected tile sequence into queues;
// monitors pop and compare whenever a tile is accepted (valid && ready).
module tb_mlp_weight_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic w_ready = 1'b1;
    logic b_ready = 1'b1;
    logic r2_ready = 1'b1;

    // Default-parameter DUT signals
    logic         busy, done;
    logic         w_rd_en, b_rd_en;
    logic [1:0]   w_rd_addr;
    logic [0:0]   b_rd_addr;
    logic [127:0] w_rd_data = 128'd0;
    logic [63:0]  b_rd_data = 64'd0;
    logic [15:0]  weight [8];
    logic [15:0]  bias [4];
    logic         weight_valid, bias_valid;

    // Degenerate (all depths 1) DUT signals
    logic         busy2, done2;
    logic         w2_rd_en, b2_rd_en;
    logic [0:0]   w2_rd_addr, b2_rd_addr;
    logic [127:0] w2_rd_data = 128'd0;
    logic [63:0]  b2_rd_data = 64'd0;
    logic [15:0]  weight2 [8];
    logic [15:0]  bias2 [4];
    logic         weight2_valid, bias2_valid;

    logic [127:0] w_packed, w2_packed;
    logic [63:0]  b_packed, b2_packed;

    logic [127:0] wq[$];
    logic [63:0]  bq[$];
    logic [127:0] wq2[$];
    logic [63:0]  bq2[$];

    int tests = 0;
    int fails = 0;
    int w_seen, b_seen, done_cnt;
    int w2_seen, b2_seen, done2_cnt;
    int stall_reads;
    int n;

    mlp_weight_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .weight_rd_en(w_rd_en), .weight_rd_addr(w_rd_addr), .weight_rd_data(w_rd_data),
        .bias_rd_en(b_rd_en), .bias_rd_addr(b_rd_addr), .bias_rd_data(b_rd_data),
        .weight(weight), .weight_valid(weight_valid), .weight_ready(w_ready),
        .bias(bias), .bias_valid(bias_valid), .bias_ready(b_ready)
    );

    mlp_weight_sequencer #(.IN_Y(4), .IN_X(2), .W_Y(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .weight_rd_en(w2_rd_en), .weight_rd_addr(w2_rd_addr), .weight_rd_data(w2_rd_data),
        .bias_rd_en(b2_rd_en), .bias_rd_addr(b2_rd_addr), .bias_rd_data(b2_rd_data),
        .weight(weight2), .weight_valid(weight2_valid), .weight_ready(r2_ready),
        .bias(bias2), .bias_valid(bias2_valid), .bias_ready(r2_ready)
    );

    always #5 clk = ~clk;

    // Weight element i of tile a is 16'h57<a><i>; bias element is 16'hB1<a><i>.
    function automatic logic [127:0] wword(input int a);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = {8'h57, 4'(a), 4'(i)};
        return r;
    endfunction

    function automatic logic [63:0] bword(input int a);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = {8'hB1, 4'(a), 4'(i)};
        return r;
    endfunction

    // Memory models: synchronous read, one cycle latency.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wword(int'(w_rd_addr));
        if (b_rd_en) b_rd_data <= bword(int'(b_rd_addr));
        if (w2_rd_en) w2_rd_data <= {8{16'hA5A5}};
        if (b2_rd_en) b2_rd_data <= {4{16'hA5A5}};
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_packed[i*16 +: 16]  = weight[i];
            w2_packed[i*16 +: 16] = weight2[i];
        end
        for (int i = 0; i < 4; i++) begin
            b_packed[i*16 +: 16]  = bias[i];
            b2_packed[i*16 +: 16] = bias2[i];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic extra_tile(input string name, input logic [127:0] act);
        tests++;
        fails++;
        $display("FAIL %s: actual=unexpected tile %h required=no tile", name, act);
    endtask

    // Monitors: compare every accepted tile against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            if (weight_valid && w_ready) begin
                if (wq.size() == 0) extra_tile("w_extra", w_packed);
                else chkw("w_tile", w_packed, wq.pop_front());
                w_seen++;
            end
            if (bias_valid && b_ready) begin
                if (bq.size() == 0) extra_tile("b_extra", {64'd0, b_packed});
                else chkw("b_tile", {64'd0, b_packed}, {64'd0, bq.pop_front()});
                b_seen++;
            end
            if (weight2_valid && r2_ready) begin
                if (wq2.size() == 0) extra_tile("w2_extra", w2_packed);
                else chkw("w2_tile", w2_packed, wq2.pop_front());
                w2_seen++;
            end
            if (bias2_valid && r2_ready) begin
                if (bq2.size() == 0) extra_tile("b2_extra", {64'd0, b2_packed});
                else chkw("b2_tile", {64'd0, b2_packed}, {64'd0, bq2.pop_front()});
                b2_seen++;
            end
            if (done) done_cnt++;
            if (done2) done2_cnt++;
        end
    end

    task automatic check_reset(input string name);
        chk1({name, "_busy"}, busy, 1'b0);
        chk1({name, "_done"}, done, 1'b0);
        chk1({name, "_w_rd_en"}, w_rd_en, 1'b0);
        chkw({name, "_w_rd_addr"}, 128'(w_rd_addr), 128'd0);
        chk1({name, "_b_rd_en"}, b_rd_en, 1'b0);
        chkw({name, "_b_rd_addr"}, 128'(b_rd_addr), 128'd0);
        chk1({name, "_w_valid"}, weight_valid, 1'b0);
        chk1({name, "_b_valid"}, bias_valid, 1'b0);
    endtask

    // Queue the expected order and pulse start; returns just inside cycle 1.
    task automatic begin_pass();
        w_seen = 0;
        b_seen = 0;
        done_cnt = 0;
        for (int y = 0; y < 4; y++) begin
            for (int w = 0; w < 2; w++) begin
                for (int x = 0; x < 2; x++) wq.push_back(wword(w * 2 + x));
                bq.push_back(bword(w));
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk1({name, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic end_pass(input string name);
        repeat (2) @(negedge clk);
        chki({name, "_w_count"}, w_seen, 16);
        chki({name, "_b_count"}, b_seen, 8);
        chki({name, "_done_pulses"}, done_cnt, 1);
        chki({name, "_wq_left"}, wq.size(), 0);
        chki({name, "_bq_left"}, bq.size(), 0);
        chk1({name, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=time limit reached required=bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        chk1("reset_busy2", busy2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Pass 1: free-running, latency checks
        begin_pass();
        @(negedge clk);
        chk1("c1_busy", busy, 1'b1);
        chk1("c1_w_rd_en", w_rd_en, 1'b1);
        chkw("c1_w_addr", 128'(w_rd_addr), 128'd0);
        chk1("c1_b_rd_en", b_rd_en, 1'b1);
        chkw("c1_b_addr", 128'(b_rd_addr), 128'd0);
        chk1("c1_w_valid", weight_valid, 1'b0);
        @(negedge clk);
        chk1("c2_w_valid", weight_valid, 1'b0);
        @(negedge clk);
        chk1("c3_w_valid", weight_valid, 1'b1);
        chk1("c3_b_valid", bias_valid, 1'b1);
        wait_idle("p1");
        end_pass("p1");

        // Pass 2: weight_ready low for cycles 4..13
        stall_reads = 0;
        begin_pass();
        for (int c = 1; c <= 14; c++) begin
            if (c == 4) w_ready = 1'b0;
            if (c == 14) w_ready = 1'b1;
            @(negedge clk);
            if (c >= 4 && c <= 13) begin
                chk1("stall_w_valid", weight_valid, 1'b1);
                chkw("stall_tile", w_packed, wword(1));
                if (w_rd_en) stall_reads++;
            end
            @(posedge clk);
            #1;
        end
        chk1("stall_reads_le2", (stall_reads <= 2), 1'b1);
        wait_idle("p2");
        end_pass("p2");

        // Pass 3: bias_ready low until every weight tile is consumed
        b_ready = 1'b0;
        begin_pass();
        n = 0;
        while (w_seen < 16 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chki("p3_w_all", w_seen, 16);
        repeat (3) @(negedge clk);
        chk1("p3_busy", busy, 1'b1);
        chk1("p3_done", done, 1'b0);
        chk1("p3_b_valid", bias_valid, 1'b1);
        chki("p3_b_seen", b_seen, 0);
        @(posedge clk);
        #1 b_ready = 1'b1;
        wait_idle("p3");
        end_pass("p3");

        // Pass 4: reset in cycle 7, then a fresh pass from address 0
        begin_pass();
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset("midreset");
        wq.delete();
        bq.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        begin_pass();
        @(negedge clk);
        chk1("p4_w_rd_en", w_rd_en, 1'b1);
        chkw("p4_w_addr", 128'(w_rd_addr), 128'd0);
        chk1("p4_b_rd_en", b_rd_en, 1'b1);
        chkw("p4_b_addr", 128'(b_rd_addr), 128'd0);
        wait_idle("p4");
        end_pass("p4");

        // Pass 5: start re-asserted during RUN must be ignored
        begin_pass();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("p5");
        end_pass("p5");
        repeat (4) @(negedge clk);
        chk1("p5_stays_idle", busy, 1'b0);

        // Degenerate instance: one weight tile and one bias tile
        w2_seen = 0;
        b2_seen = 0;
        done2_cnt = 0;
        wq2.push_back({8{16'hA5A5}});
        bq2.push_back({4{16'hA5A5}});
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (busy2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("d_idle_timeout", busy2, 1'b0);
        repeat (2) @(negedge clk);
        chki("d_w_count", w2_seen, 1);
        chki("d_b_count", b2_seen, 1);
        chki("d_done_pulses", done2_cnt, 1);
        chki("d_wq_left", wq2.size(), 0);
        chki("d_bq_left", bq2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
